// File: rtl/scrypt_pad_pkg.sv
// Shared types and helpers for the scrypt scratchpad sequencer.
// Entry/beat addresses are built by one function so fill and mix paths agree on layout.
package scrypt_pad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        MIX   = 2'd2,
        FLUSH = 2'd3
    } pad_state_t;

    localparam int BEATS    = 4;
    localparam int BEATBITS = 2;
    localparam int MAXIDX   = 30;

    // Callers zero-extend the entry into MAXIDX bits and truncate the result to their address width.
    function automatic logic [MAXIDX+BEATBITS-1:0] pad_addr(
        input logic [MAXIDX-1:0]   entry,
        input logic [BEATBITS-1:0] beat
    );
        return {entry, beat};
    endfunction

endpackage

// File: rtl/scratchpad_ctrl.sv
// Scratchpad RAM sequencer: streams fill beats into V[] and turns mix index requests
// into four-beat read bursts, generating all RAM address/data/enable signals.
module scratchpad_ctrl
    import scrypt_pad_pkg::*;
#(
    parameter int INDEXBITS = 10
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [255:0]           wr_data,
    input  logic                   rq_valid,
    output logic                   rq_ready,
    input  logic [INDEXBITS-1:0]   rq_index,
    output logic                   rd_valid,
    output logic [255:0]           rd_data,
    output logic                   rd_last,
    output logic                   done,
    output logic                   busy,
    output logic [INDEXBITS+1:0]   ram_waddr,
    output logic [255:0]           ram_data,
    output logic                   ram_wren,
    output logic [INDEXBITS+1:0]   ram_raddr,
    input  logic [255:0]           ram_q
);

    localparam int ADDRBITS = INDEXBITS + BEATBITS;
    localparam logic [BEATBITS-1:0] LAST_BEAT = BEATBITS'(BEATS - 1);

    pad_state_t             state_reg;
    logic [INDEXBITS-1:0]   entry_reg;
    logic [BEATBITS-1:0]    beat_reg;
    logic [INDEXBITS-1:0]   j_reg;
    logic [BEATBITS-1:0]    rbeat_reg;
    logic [INDEXBITS:0]     mix_cnt_reg;
    logic                   issue_reg;
    logic                   rd_valid_reg;
    logic                   rd_last_reg;
    logic                   done_reg;
    logic                   wren_reg;
    logic [255:0]           data_reg;
    logic [ADDRBITS-1:0]    raddr_reg;

    logic wr_fire;
    logic rq_fire;
    logic last_issue;
    logic fill_last;
    logic mix_full;

    assign last_issue = issue_reg && (rbeat_reg == LAST_BEAT);
    // mix_cnt counts to exactly N = 2**INDEXBITS, so its MSB alone flags the final request.
    assign mix_full   = mix_cnt_reg[INDEXBITS];

    assign wr_ready  = (state_reg == FILL);
    assign rq_ready  = (state_reg == MIX) && !mix_full && (!issue_reg || last_issue);
    assign wr_fire   = wr_valid && wr_ready;
    assign rq_fire   = rq_valid && rq_ready;
    assign fill_last = wr_fire && (beat_reg == LAST_BEAT) && (&entry_reg);

    // The RAM registers this address internally, so it leads the registered data/wren by a cycle.
    assign ram_waddr = ADDRBITS'(pad_addr(MAXIDX'(entry_reg), beat_reg));
    assign ram_data  = data_reg;
    assign ram_wren  = wren_reg;
    assign ram_raddr = raddr_reg;

    assign rd_valid = rd_valid_reg;
    assign rd_data  = ram_q;
    assign rd_last  = rd_last_reg;
    assign done     = done_reg;
    assign busy     = (state_reg != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            entry_reg    <= '0;
            beat_reg     <= '0;
            j_reg        <= '0;
            rbeat_reg    <= '0;
            mix_cnt_reg  <= '0;
            issue_reg    <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
            done_reg     <= 1'b0;
            wren_reg     <= 1'b0;
            data_reg     <= '0;
            raddr_reg    <= '0;
        end else begin
            wren_reg <= wr_fire;
            if (wr_fire) begin
                data_reg <= wr_data;
                beat_reg <= beat_reg + 1'b1;
                if (beat_reg == LAST_BEAT) begin
                    entry_reg <= entry_reg + 1'b1;
                end
            end

            rd_valid_reg <= issue_reg;
            rd_last_reg  <= last_issue;
            done_reg     <= last_issue && mix_full;

            // A new accept on the last issue cycle restarts the burst with no gap.
            if (rq_fire) begin
                j_reg       <= rq_index;
                rbeat_reg   <= '0;
                issue_reg   <= 1'b1;
                raddr_reg   <= ADDRBITS'(pad_addr(MAXIDX'(rq_index), '0));
                mix_cnt_reg <= mix_cnt_reg + 1'b1;
            end else if (issue_reg) begin
                if (last_issue) begin
                    issue_reg <= 1'b0;
                end else begin
                    rbeat_reg <= rbeat_reg + 1'b1;
                    raddr_reg <= ADDRBITS'(pad_addr(MAXIDX'(j_reg), rbeat_reg + 1'b1));
                end
            end

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= FILL;
                        entry_reg   <= '0;
                        beat_reg    <= '0;
                        mix_cnt_reg <= '0;
                    end
                end
                FILL: begin
                    if (fill_last) begin
                        state_reg <= MIX;
                    end
                end
                MIX: begin
                    if (last_issue && mix_full) begin
                        state_reg <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (rd_last_reg) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
